// File: rtl/ad_ip_jesd204_tpl_adc_deframer_aligned.sv
// JESD204 transport-layer ADC deframer with SOF-tracking frame alignment.
// Locks onto the start-of-frame octet offset, realigns each lane to frame
// boundaries and unpacks frames into per-channel 16-bit extended samples.
module ad_ip_jesd204_tpl_adc_deframer_aligned #(
    parameter int NUM_LANES            = 1,
    parameter int NUM_CHANNELS         = 4,
    parameter int BITS_PER_SAMPLE      = 16,
    parameter int CONVERTER_RESOLUTION = 14,
    parameter int SAMPLES_PER_FRAME    = 1,
    parameter int OCTETS_PER_BEAT      = 4,
    parameter int TWOS_COMPLEMENT      = 1,
    parameter int LOCK_COUNT           = 4,
    localparam int LINK_DATA_WIDTH     = OCTETS_PER_BEAT*8*NUM_LANES,
    localparam int SAMPLES_PER_BEAT    = LINK_DATA_WIDTH/BITS_PER_SAMPLE,
    localparam int OFFSET_WIDTH        = $clog2(OCTETS_PER_BEAT)
) (
    input  logic                           clk,
    input  logic                           resetn,
    input  logic                           link_valid,
    input  logic [OCTETS_PER_BEAT-1:0]     link_sof,
    input  logic [LINK_DATA_WIDTH-1:0]     link_data,
    input  logic                           clear_err,
    output logic                           adc_valid,
    output logic [SAMPLES_PER_BEAT*16-1:0] adc_data,
    output logic                           locked,
    output logic [OFFSET_WIDTH-1:0]        sof_offset,
    output logic [7:0]                     align_err_count
);

    localparam int OCTETS_PER_FRAME    = NUM_CHANNELS*SAMPLES_PER_FRAME*BITS_PER_SAMPLE/(8*NUM_LANES);
    localparam int FRAMES_PER_BEAT     = OCTETS_PER_BEAT/OCTETS_PER_FRAME;
    localparam int FRAME_BITS          = OCTETS_PER_FRAME*8*NUM_LANES;
    localparam int SAMPLES_PER_CHANNEL = SAMPLES_PER_BEAT/NUM_CHANNELS;
    localparam logic [15:0] EXT_MASK   = 16'hFFFF << CONVERTER_RESOLUTION;

    typedef enum logic [1:0] {ST_UNLOCKED, ST_CHECK, ST_LOCKED} state_t;

    state_t                          state, state_next;
    logic [3:0]                      match_cnt, match_cnt_next, match_cnt_inc;
    logic                            locked_next;
    logic [OFFSET_WIDTH-1:0]         offset_next, obs;
    logic [7:0]                      err_next;
    logic                            have_sof;
    logic [LINK_DATA_WIDTH-1:0]      prev, aligned;
    logic [SAMPLES_PER_BEAT*16-1:0]  samples;
    logic [FRAME_BITS-1:0]           frame;
    logic [BITS_PER_SAMPLE-1:0]      word;
    logic [CONVERTER_RESOLUTION-1:0] top;
    int unsigned                     src, dst;

    // Observed SOF offset: index of the lowest set marker bit.
    always_comb begin
        obs      = '0;
        have_sof = 1'b0;
        for (int unsigned i = 0; i < OCTETS_PER_BEAT; i++) begin
            if (link_sof[i] && !have_sof) begin
                obs      = OFFSET_WIDTH'(i);
                have_sof = 1'b1;
            end
        end
    end

    // Alignment FSM next state; only valid beats carrying a SOF advance it.
    always_comb begin
        state_next     = state;
        match_cnt_next = match_cnt;
        match_cnt_inc  = match_cnt + 4'd1;
        locked_next    = locked;
        offset_next    = sof_offset;
        err_next       = align_err_count;
        if (link_valid && have_sof) begin
            unique case (state)
                ST_UNLOCKED: begin
                    offset_next    = obs;
                    match_cnt_next = 4'd1;
                    if (LOCK_COUNT == 1) begin
                        state_next  = ST_LOCKED;
                        locked_next = 1'b1;
                    end else begin
                        state_next  = ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (obs == sof_offset) begin
                        match_cnt_next = match_cnt_inc;
                        if (match_cnt_inc == 4'(LOCK_COUNT)) begin
                            state_next  = ST_LOCKED;
                            locked_next = 1'b1;
                        end
                    end else begin
                        offset_next    = obs;
                        match_cnt_next = 4'd1;
                    end
                end
                ST_LOCKED: begin
                    if (obs != sof_offset) begin
                        state_next     = ST_CHECK;
                        locked_next    = 1'b0;
                        offset_next    = obs;
                        match_cnt_next = 4'd1;
                        if (align_err_count != 8'hFF) begin
                            err_next = align_err_count + 8'd1;
                        end
                    end
                end
                default: state_next = ST_UNLOCKED;
            endcase
        end
        if (clear_err) begin
            err_next = '0;
        end
    end

    // Alignment FSM and status registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state           <= ST_UNLOCKED;
            match_cnt       <= '0;
            locked          <= 1'b0;
            sof_offset      <= '0;
            align_err_count <= '0;
        end else begin
            state           <= state_next;
            match_cnt       <= match_cnt_next;
            locked          <= locked_next;
            sof_offset      <= offset_next;
            align_err_count <= err_next;
        end
    end

    // Per-lane realignment: a non-zero offset stitches the previous beat's
    // tail to the current beat's head, offset zero passes the current beat.
    always_comb begin
        aligned = '0;
        src     = 0;
        for (int unsigned l = 0; l < NUM_LANES; l++) begin
            for (int unsigned k = 0; k < OCTETS_PER_BEAT; k++) begin
                src = k + 32'(sof_offset);
                if (sof_offset == '0) begin
                    aligned[(l*OCTETS_PER_BEAT+k)*8 +: 8] = link_data[(l*OCTETS_PER_BEAT+k)*8 +: 8];
                end else if (src < OCTETS_PER_BEAT) begin
                    aligned[(l*OCTETS_PER_BEAT+k)*8 +: 8] = prev[(l*OCTETS_PER_BEAT+src)*8 +: 8];
                end else begin
                    aligned[(l*OCTETS_PER_BEAT+k)*8 +: 8] = link_data[(l*OCTETS_PER_BEAT+src-OCTETS_PER_BEAT)*8 +: 8];
                end
            end
        end
    end

    // Deframing: each frame is the lane-ordered concatenation of its octets
    // (earliest octet most significant), split converter-major into samples.
    always_comb begin
        samples = '0;
        frame   = '0;
        word    = '0;
        top     = '0;
        dst     = 0;
        for (int unsigned f = 0; f < FRAMES_PER_BEAT; f++) begin
            for (int unsigned l = 0; l < NUM_LANES; l++) begin
                for (int unsigned i = 0; i < OCTETS_PER_FRAME; i++) begin
                    frame[FRAME_BITS-1-(l*OCTETS_PER_FRAME+i)*8 -: 8] =
                        aligned[(l*OCTETS_PER_BEAT+f*OCTETS_PER_FRAME+i)*8 +: 8];
                end
            end
            for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
                for (int unsigned s = 0; s < SAMPLES_PER_FRAME; s++) begin
                    word = frame[FRAME_BITS-1-(c*SAMPLES_PER_FRAME+s)*BITS_PER_SAMPLE -: BITS_PER_SAMPLE];
                    top  = CONVERTER_RESOLUTION'(word >> (BITS_PER_SAMPLE-CONVERTER_RESOLUTION));
                    dst  = c*SAMPLES_PER_CHANNEL + f*SAMPLES_PER_FRAME + s;
                    if (dst < SAMPLES_PER_BEAT) begin
                        samples[dst*16 +: 16] = 16'(top) |
                            ((TWOS_COMPLEMENT != 0 && top[CONVERTER_RESOLUTION-1]) ? EXT_MASK : 16'h0000);
                    end
                end
            end
        end
    end

    // Output and previous-beat registers; everything holds across gaps.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            adc_valid <= 1'b0;
            adc_data  <= '0;
            prev      <= '0;
        end else begin
            adc_valid <= link_valid & locked;
            if (link_valid) begin
                adc_data <= samples;
                prev     <= link_data;
            end
        end
    end

endmodule

// File: tb/tb_ad_ip_jesd204_tpl_adc_deframer_aligned.sv
// Self-checking bench: octet-stream reference model vs three DUT configs.
module tb_ad_ip_jesd204_tpl_adc_deframer_aligned;

    logic clk = 1'b0;
    logic resetn;
    int   checks, errors;

    // Config A/Z: L=1 M=1 S=1 N'=16 N=14 OPB=4 (A sign-extends, Z zero-extends)
    logic        a_valid, a_clr;
    logic [3:0]  a_sof;
    logic [31:0] a_data;
    logic        adc_valid_a, locked_a, adc_valid_z, locked_z;
    logic [31:0] adc_data_a, adc_data_z;
    logic [1:0]  sof_offset_a, sof_offset_z;
    logic [7:0]  align_err_a, align_err_z;

    // Config M: L=2 M=4 S=1 N'=16 N=12 OPB=8
    logic         m_valid, m_clr;
    logic [7:0]   m_sof;
    logic [127:0] m_data;
    logic         adc_valid_m, locked_m;
    logic [127:0] adc_data_m;
    logic [2:0]   sof_offset_m;
    logic [7:0]   align_err_m;

    // Reference model state
    bit           ma_locked, mm_locked;
    int           ma_off, ma_run, ma_err, mm_off, mm_run, mm_err;
    logic [255:0] ma_prev, mm_prev, ea_data, ez_data, em_data;
    logic         ea_valid, em_valid;

    ad_ip_jesd204_tpl_adc_deframer_aligned #(
        .NUM_LANES(1), .NUM_CHANNELS(1), .BITS_PER_SAMPLE(16), .CONVERTER_RESOLUTION(14),
        .SAMPLES_PER_FRAME(1), .OCTETS_PER_BEAT(4), .TWOS_COMPLEMENT(1), .LOCK_COUNT(4)
    ) dut_a (
        .clk(clk), .resetn(resetn), .link_valid(a_valid), .link_sof(a_sof), .link_data(a_data),
        .clear_err(a_clr), .adc_valid(adc_valid_a), .adc_data(adc_data_a), .locked(locked_a),
        .sof_offset(sof_offset_a), .align_err_count(align_err_a)
    );

    ad_ip_jesd204_tpl_adc_deframer_aligned #(
        .NUM_LANES(1), .NUM_CHANNELS(1), .BITS_PER_SAMPLE(16), .CONVERTER_RESOLUTION(14),
        .SAMPLES_PER_FRAME(1), .OCTETS_PER_BEAT(4), .TWOS_COMPLEMENT(0), .LOCK_COUNT(4)
    ) dut_z (
        .clk(clk), .resetn(resetn), .link_valid(a_valid), .link_sof(a_sof), .link_data(a_data),
        .clear_err(a_clr), .adc_valid(adc_valid_z), .adc_data(adc_data_z), .locked(locked_z),
        .sof_offset(sof_offset_z), .align_err_count(align_err_z)
    );

    ad_ip_jesd204_tpl_adc_deframer_aligned #(
        .NUM_LANES(2), .NUM_CHANNELS(4), .BITS_PER_SAMPLE(16), .CONVERTER_RESOLUTION(12),
        .SAMPLES_PER_FRAME(1), .OCTETS_PER_BEAT(8), .TWOS_COMPLEMENT(1), .LOCK_COUNT(4)
    ) dut_m (
        .clk(clk), .resetn(resetn), .link_valid(m_valid), .link_sof(m_sof), .link_data(m_data),
        .clear_err(m_clr), .adc_valid(adc_valid_m), .adc_data(adc_data_m), .locked(locked_m),
        .sof_offset(sof_offset_m), .align_err_count(align_err_m)
    );

    always #5 clk = ~clk;

    // Reference deframer: time-ordered octet stream per lane -> frames -> samples.
    function automatic logic [255:0] ref_beat(input int nl, input int nm, input int ns, input int np,
                                              input int nn, input int opb, input int tc,
                                              input logic [255:0] prv, input logic [255:0] cur,
                                              input int off);
        logic [7:0]   al [0:7][0:7];
        logic [127:0] fv, word, top;
        logic [15:0]  ext;
        logic [255:0] res;
        int fo, frames, spc, fbits;
        fo     = nm*ns*np/(8*nl);
        frames = opb/fo;
        spc    = frames*ns;
        fbits  = fo*8*nl;
        res    = '0;
        for (int l = 0; l < nl; l++)
            for (int k = 0; k < opb; k++)
                if (off == 0)           al[l][k] = cur[(l*opb+k)*8 +: 8];
                else if (k < opb - off) al[l][k] = prv[(l*opb+off+k)*8 +: 8];
                else                    al[l][k] = cur[(l*opb+k-(opb-off))*8 +: 8];
        for (int f = 0; f < frames; f++) begin
            fv = '0;
            for (int l = 0; l < nl; l++)
                for (int i = 0; i < fo; i++)
                    fv = (fv << 8) | 128'(al[l][f*fo+i]);
            for (int c = 0; c < nm; c++)
                for (int s = 0; s < ns; s++) begin
                    word = (fv >> (fbits - (c*ns+s+1)*np)) & ((128'd1 << np) - 128'd1);
                    top  = word >> (np - nn);
                    ext  = top[15:0];
                    if (tc != 0 && top[nn-1]) ext = ext | (16'hFFFF << nn);
                    res[(c*spc + f*ns + s)*16 +: 16] = ext;
                end
        end
        return res;
    endfunction

    // Lock model: run length of identical SOF offsets; a change while locked is an error.
    task automatic fsm_model(input logic v, input logic [7:0] sof, input logic clr, input int lock_n,
                             inout bit lk, inout int off, inout int run, inout int err);
        int o;
        if (v && sof != 8'd0) begin
            o = 0;
            for (int i = 7; i >= 0; i--) if (sof[i]) o = i;
            if (run > 0 && o == off) run++;
            else begin
                if (lk) err = (err < 255) ? err + 1 : 255;
                lk  = 0;
                off = o;
                run = 1;
            end
            if (run >= lock_n) lk = 1;
        end
        if (clr) err = 0;
    endtask

    task automatic model_reset();
        ma_locked = 0; ma_off = 0; ma_run = 0; ma_err = 0; ma_prev = '0;
        mm_locked = 0; mm_off = 0; mm_run = 0; mm_err = 0; mm_prev = '0;
        ea_valid = 0; ea_data = '0; ez_data = '0; em_valid = 0; em_data = '0;
    endtask

    task automatic beat_a(input logic v, input logic [3:0] sof, input logic [31:0] d, input logic clr);
        logic [255:0] cur;
        a_valid = v; a_sof = sof; a_data = d; a_clr = clr;
        @(posedge clk); #1;
        cur      = 256'(d);
        ea_valid = v && ma_locked;
        if (v) begin
            ea_data = ref_beat(1, 1, 1, 16, 14, 4, 1, ma_prev, cur, ma_off);
            ez_data = ref_beat(1, 1, 1, 16, 14, 4, 0, ma_prev, cur, ma_off);
            ma_prev = cur;
        end
        fsm_model(v, 8'(sof), clr, 4, ma_locked, ma_off, ma_run, ma_err);
    endtask

    task automatic beat_m(input logic v, input logic [7:0] sof, input logic [127:0] d);
        logic [255:0] cur;
        m_valid = v; m_sof = sof; m_data = d; m_clr = 1'b0;
        @(posedge clk); #1;
        cur      = 256'(d);
        em_valid = v && mm_locked;
        if (v) begin
            em_data = ref_beat(2, 4, 1, 16, 12, 8, 1, mm_prev, cur, mm_off);
            mm_prev = cur;
        end
        fsm_model(v, sof, 1'b0, 4, mm_locked, mm_off, mm_run, mm_err);
    endtask

    task automatic reset_all();
        resetn = 0;
        a_valid = 0; a_sof = '0; a_data = '0; a_clr = 0;
        m_valid = 0; m_sof = '0; m_data = '0; m_clr = 0;
        model_reset();
        @(posedge clk); #2;
        resetn = 1;
        #1;
    endtask

    task automatic test_reset();
        resetn = 0;
        a_valid = 1; a_sof = 4'b0101; a_data = $urandom; a_clr = 0;
        m_valid = 1; m_sof = 8'h11; m_data = {$urandom, $urandom, $urandom, $urandom}; m_clr = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({adc_valid_a, locked_a, sof_offset_a, align_err_a, adc_data_a} !== '0) begin
            errors++; $display("FAIL reset_a: got v=%b l=%b off=%0d err=%0d data=%h required all 0",
                               adc_valid_a, locked_a, sof_offset_a, align_err_a, adc_data_a);
        end
        checks++;
        if ({adc_valid_z, locked_z, sof_offset_z, align_err_z, adc_data_z} !== '0) begin
            errors++; $display("FAIL reset_z: got v=%b l=%b data=%h required all 0", adc_valid_z, locked_z, adc_data_z);
        end
        checks++;
        if ({adc_valid_m, locked_m, sof_offset_m, align_err_m, adc_data_m} !== '0) begin
            errors++; $display("FAIL reset_m: got v=%b l=%b data=%h required all 0", adc_valid_m, locked_m, adc_data_m);
        end
        reset_all();
    endtask

    task automatic test_lock_timing();
        reset_all();
        for (int i = 0; i < 5; i++) begin
            beat_a(1, 4'b0101, $urandom, 0);
            checks++;
            if (locked_a !== 1'(i >= 3)) begin
                errors++; $display("FAIL lock_timing locked beat %0d: got %b required %b", i+1, locked_a, i >= 3);
            end
            checks++;
            if (adc_valid_a !== 1'(i >= 4)) begin
                errors++; $display("FAIL lock_timing adc_valid beat %0d: got %b required %b", i+1, adc_valid_a, i >= 4);
            end
        end
        checks++;
        if (sof_offset_a !== 2'd0) begin
            errors++; $display("FAIL lock_timing sof_offset: got %0d required 0", sof_offset_a);
        end
        checks++;
        if (adc_data_a !== ea_data[31:0]) begin
            errors++; $display("FAIL lock_timing data: got %h required %h", adc_data_a, ea_data[31:0]);
        end
    endtask

    task automatic test_realign();
        reset_all();
        repeat (4) beat_a(1, 4'b1010, $urandom, 0);
        checks++;
        if (locked_a !== 1'b1 || sof_offset_a !== 2'd1) begin
            errors++; $display("FAIL realign lock: got locked=%b off=%0d required 1/1", locked_a, sof_offset_a);
        end
        beat_a(1, 4'b1010, 32'h44332211, 0);
        beat_a(1, 4'b1010, 32'h88776655, 0);
        checks++;
        if (adc_data_a !== 32'h1115088C || adc_valid_a !== 1'b1) begin
            errors++; $display("FAIL realign data: got v=%b %h required v=1 1115088c", adc_valid_a, adc_data_a);
        end
        checks++;
        if (adc_data_z !== ez_data[31:0]) begin
            errors++; $display("FAIL realign data_z: got %h required %h", adc_data_z, ez_data[31:0]);
        end
    endtask

    task automatic test_slip();
        logic [3:0] p;
        beat_a(1, 4'b0101, $urandom, 0);
        checks++;
        if (locked_a !== 1'b0 || align_err_a !== 8'd1 || sof_offset_a !== 2'd0) begin
            errors++; $display("FAIL slip: got locked=%b err=%0d off=%0d required 0/1/0", locked_a, align_err_a, sof_offset_a);
        end
        for (int k = 0; k < 3; k++) begin
            beat_a(1, 4'b0101, $urandom, 0);
            checks++;
            if (locked_a !== 1'(k == 2)) begin
                errors++; $display("FAIL slip relock beat %0d: got %b required %b", k+2, locked_a, k == 2);
            end
        end
        for (int n = 0; n < 300; n++) begin
            p = (n % 2 == 0) ? 4'b1010 : 4'b0101;
            beat_a(1, p, $urandom, 0);
            checks++;
            if (align_err_a !== 8'(ma_err)) begin
                errors++; $display("FAIL slip_count %0d: got %0d required %0d", n, align_err_a, ma_err);
            end
            repeat (3) beat_a(1, p, $urandom, 0);
        end
        checks++;
        if (align_err_a !== 8'd255 || locked_a !== 1'b1) begin
            errors++; $display("FAIL slip_saturate: got err=%0d locked=%b required 255/1", align_err_a, locked_a);
        end
        beat_a(1, 4'b1010, $urandom, 1);
        checks++;
        if (align_err_a !== 8'd0 || locked_a !== 1'b0 || sof_offset_a !== 2'd1) begin
            errors++; $display("FAIL slip_clear: got err=%0d locked=%b off=%0d required 0/0/1", align_err_a, locked_a, sof_offset_a);
        end
        a_clr = 0;
    endtask

    task automatic test_extension();
        reset_all();
        repeat (4) beat_a(1, 4'b0101, $urandom, 0);
        beat_a(1, 4'b0101, 32'h0000FCFF, 0);
        checks++;
        if (adc_data_a[15:0] !== 16'hFFFF) begin
            errors++; $display("FAIL ext_sign: got %h required ffff", adc_data_a[15:0]);
        end
        checks++;
        if (adc_data_z[15:0] !== 16'h3FFF) begin
            errors++; $display("FAIL ext_zero: got %h required 3fff", adc_data_z[15:0]);
        end
        for (int i = 0; i < 20; i++) begin
            beat_a(1, 4'b0101, $urandom, 0);
            checks++;
            if (adc_data_a !== ea_data[31:0] || adc_data_z !== ez_data[31:0]) begin
                errors++; $display("FAIL ext_random %0d: got %h/%h required %h/%h",
                                   i, adc_data_a, adc_data_z, ea_data[31:0], ez_data[31:0]);
            end
        end
    endtask

    task automatic test_gaps();
        beat_a(1, 4'b0101, $urandom, 0);
        checks++;
        if (adc_valid_a !== 1'b1 || adc_data_a !== ea_data[31:0]) begin
            errors++; $display("FAIL gap_pre: got v=%b %h required v=1 %h", adc_valid_a, adc_data_a, ea_data[31:0]);
        end
        beat_a(0, 4'b1010, $urandom, 0);
        checks++;
        if (adc_valid_a !== 1'b0 || adc_data_a !== ea_data[31:0]) begin
            errors++; $display("FAIL gap_hold: got v=%b %h required v=0 %h", adc_valid_a, adc_data_a, ea_data[31:0]);
        end
        checks++;
        if (locked_a !== 1'b1 || sof_offset_a !== 2'd0 || align_err_a !== 8'd0) begin
            errors++; $display("FAIL gap_fsm: got locked=%b off=%0d err=%0d required 1/0/0", locked_a, sof_offset_a, align_err_a);
        end
        beat_a(1, 4'b0101, $urandom, 0);
        checks++;
        if (adc_valid_a !== 1'b1 || adc_data_a !== ea_data[31:0]) begin
            errors++; $display("FAIL gap_post: got v=%b %h required v=1 %h", adc_valid_a, adc_data_a, ea_data[31:0]);
        end
    endtask

    task automatic test_reset_midstream();
        a_valid = 1; a_sof = 4'b0101; a_data = $urandom; a_clr = 0;
        checks++;
        if (adc_valid_a !== ea_valid || ea_valid !== 1'b1) begin
            errors++; $display("FAIL midreset_pre: got v=%b required 1", adc_valid_a);
        end
        #2;
        resetn = 0;
        #1;
        checks++;
        if ({adc_valid_a, locked_a, sof_offset_a, align_err_a, adc_data_a} !== '0) begin
            errors++; $display("FAIL midreset: got v=%b l=%b off=%0d data=%h required all 0",
                               adc_valid_a, locked_a, sof_offset_a, adc_data_a);
        end
        model_reset();
        #1;
        resetn = 1;
        for (int i = 0; i < 4; i++) begin
            beat_a(1, 4'b0101, $urandom, 0);
            checks++;
            if (locked_a !== 1'(i == 3)) begin
                errors++; $display("FAIL midreset_relock beat %0d: got %b required %b", i+1, locked_a, i == 3);
            end
        end
    endtask

    function automatic logic [127:0] ramp(input logic [7:0] b0, input logic [7:0] b1, input int beat);
        logic [127:0] d;
        for (int k = 0; k < 8; k++) begin
            d[k*8 +: 8]      = 8'(int'(b0) + beat*8 + k);
            d[(8+k)*8 +: 8]  = 8'(int'(b1) + beat*8 + k);
        end
        return d;
    endfunction

    task automatic test_multilane();
        int         off, b;
        logic [7:0] sof, b0, b1;
        logic       v;
        reset_all();
        off = $urandom_range(0, 3);
        sof = 8'(1 << off) | 8'(1 << (off + 4));
        b0  = 8'($urandom);
        b1  = 8'($urandom);
        b   = 0;
        repeat (4) begin beat_m(1, sof, ramp(b0, b1, b)); b++; end
        checks++;
        if (locked_m !== 1'b1 || sof_offset_m !== 3'(off)) begin
            errors++; $display("FAIL multilane_lock: got locked=%b off=%0d required 1/%0d", locked_m, sof_offset_m, off);
        end
        for (int n = 0; n < 1000; n++) begin
            v = ($urandom_range(0, 9) != 0);
            beat_m(v, sof, v ? ramp(b0, b1, b) : {$urandom, $urandom, $urandom, $urandom});
            if (v) b++;
            checks++;
            if (adc_valid_m !== em_valid || adc_data_m !== em_data[127:0] || locked_m !== 1'b1) begin
                errors++; $display("FAIL multilane beat %0d: got v=%b l=%b %h required v=%b l=1 %h",
                                   n, adc_valid_m, locked_m, adc_data_m, em_valid, em_data[127:0]);
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_lock_timing();
        test_realign();
        test_slip();
        test_extension();
        test_gaps();
        test_reset_midstream();
        test_multilane();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
